// File: rtl/unibus_mem.sv
// Unibus memory slave backed by block RAM; answers DATI/DATIP/DATO/DATOB in a base/limit window.
// Optional statistics register 3 (and version 12'h013) when UNIBUS_MEM_STATS_EN is defined.
`timescale 1ns/1ps

module unibus_mem #(
  parameter int MEMWORDS = 16384,
  parameter int DESKEW   = 15
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        msyn_in_h,
  input  logic        init_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h
);

  localparam int          AW      = (MEMWORDS > 1) ? $clog2(MEMWORDS) : 1;
  localparam int          CW      = (DESKEW > 0) ? $clog2(DESKEW + 1) : 1;
  localparam logic [17:0] IO_PAGE = 18'o760000;
`ifdef UNIBUS_MEM_STATS_EN
  localparam logic [11:0] VERSION = 12'h013;
`else
  localparam logic [11:0] VERSION = 12'h003;
`endif
  localparam logic [31:0] ID_WORD = {16'h554D, 4'h2, VERSION};

  typedef enum logic [1:0] {
    BUS_DATI  = 2'b00,
    BUS_DATIP = 2'b01,
    BUS_DATO  = 2'b10,
    BUS_DATOB = 2'b11
  } bus_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DESKEW,
    S_ACCESS,
    S_REPLY,
    S_HOLD
  } state_e;

  // Configuration registers
  logic        enable_q;
  logic [17:0] base_q;
  logic [17:0] limit_q;

  // Bus cycle state
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        ssyn_q, ssyn_d;
  logic [15:0] dout_q, dout_d;
  logic [AW-1:0] idx_q;
  bus_op_e     op_q;
  logic        byte_hi_q;

  // RAM
  logic [15:0] mem [0:MEMWORDS-1];
  logic [15:0] rdata_q;
  logic        ram_re, ram_we_lo, ram_we_hi;

  logic        start_cycle;
  logic        reply_entry;
  logic        is_read_q;
  logic [31:0] stats_word;
  logic        unused_stats;

  // Address decode against the live configuration
  logic [17:0] offset;
  logic [16:0] word_off;
  logic        hit;

  assign offset   = a_in_h - base_q;
  assign word_off = offset[17:1];
  assign hit      = enable_q
                  && (a_in_h >= base_q)
                  && (a_in_h < limit_q)
                  && (a_in_h < IO_PAGE)
                  && ({15'd0, word_off} < 32'(MEMWORDS));

  assign is_read_q = (op_q == BUS_DATI) || (op_q == BUS_DATIP);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      enable_q <= 1'b0;
      base_q   <= '0;
      limit_q  <= '0;
    end else if (armwrite) begin
      case (armwaddr)
        3'd1: begin
          enable_q <= armwdata[31];
          base_q   <= {armwdata[17:1], 1'b0};
        end
        3'd2:    limit_q <= {armwdata[17:1], 1'b0};
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    ssyn_d      = ssyn_q;
    dout_d      = dout_q;
    start_cycle = 1'b0;
    ram_re      = 1'b0;
    ram_we_lo   = 1'b0;
    ram_we_hi   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (msyn_in_h && hit) begin
          state_d     = S_DESKEW;
          cnt_d       = '0;
          start_cycle = 1'b1;
        end
      end
      S_DESKEW: begin
        if (!msyn_in_h) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(DESKEW)) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACCESS: begin
        case (op_q)
          BUS_DATO: begin
            ram_we_lo = 1'b1;
            ram_we_hi = 1'b1;
          end
          BUS_DATOB: begin
            ram_we_hi = byte_hi_q;
            ram_we_lo = !byte_hi_q;
          end
          default: ram_re = 1'b1;
        endcase
        state_d = S_REPLY;
      end
      S_REPLY: begin
        ssyn_d  = 1'b1;
        dout_d  = is_read_q ? rdata_q : 16'd0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!msyn_in_h) begin
          ssyn_d  = 1'b0;
          dout_d  = 16'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus init aborts whatever is in flight, including a write about to land.
    if (init_in_h) begin
      state_d     = S_IDLE;
      ssyn_d      = 1'b0;
      dout_d      = 16'd0;
      start_cycle = 1'b0;
      ram_we_lo   = 1'b0;
      ram_we_hi   = 1'b0;
    end
  end

  assign reply_entry = (state_q == S_ACCESS) && !init_in_h;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ssyn_q    <= 1'b0;
      dout_q    <= '0;
      idx_q     <= '0;
      op_q      <= BUS_DATI;
      byte_hi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ssyn_q  <= ssyn_d;
      dout_q  <= dout_d;
      if (start_cycle) begin
        idx_q     <= word_off[AW-1:0];
        op_q      <= bus_op_e'(c_in_h);
        byte_hi_q <= a_in_h[0];
      end
    end
  end

  // NOTE: the RAM array and its read register are deliberately not reset so they map onto block RAM.
  always_ff @(posedge CLOCK) begin
    if (ram_we_lo) mem[idx_q][7:0]  <= d_in_h[7:0];
    if (ram_we_hi) mem[idx_q][15:8] <= d_in_h[15:8];
    if (ram_re)    rdata_q          <= mem[idx_q];
  end

`ifdef UNIBUS_MEM_STATS_EN
  logic [15:0] reads_q;
  logic [15:0] writes_q;

  // A clear from the ARM wins over a same-clock increment.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      reads_q  <= '0;
      writes_q <= '0;
    end else if (armwrite && (armwaddr == 3'd3)) begin
      reads_q  <= '0;
      writes_q <= '0;
    end else if (reply_entry) begin
      if (is_read_q) reads_q  <= reads_q + 16'd1;
      else           writes_q <= writes_q + 16'd1;
    end
  end

  assign stats_word   = {reads_q, writes_q};
  assign unused_stats = 1'b0;
`else
  assign stats_word   = 32'd0;
  assign unused_stats = reply_entry;
`endif

  always_comb begin
    case (armraddr)
      3'd0:    armrdata = ID_WORD;
      3'd1:    armrdata = {enable_q, 13'd0, base_q};
      3'd2:    armrdata = {14'd0, limit_q};
      3'd3:    armrdata = stats_word;
      default: armrdata = 32'hDEADBEEF;
    endcase
  end

  assign ssyn_out_h = ssyn_q;
  assign d_out_h    = dout_q;

  logic unused_ok;
  assign unused_ok = ^{armwdata[30:18], armwdata[0], offset[0], word_off, unused_stats};

endmodule
